// File: rtl/sample_sched.sv
// -----------------------------------------------------------------------------
// sample_sched -- two-requester round-robin frame accumulator.
//
// A requester raises req to claim the accumulator. Once granted, each edge on
// which the owner strobes valid adds its 8-bit sample (zero-extended) into a
// 14-bit running sum. The 33rd accepted sample closes the frame: a one-cycle
// sum_valid pulse reports the sum and the owner. If the owner drops req
// mid-frame, the frame is thrown away and a one-cycle abort pulse is emitted.
//
// Optional build macro: SCHED_TIMEOUT_EN
//   When defined, an owner that goes 64 consecutive BURST cycles without
//   delivering a sample is aborted as if it had dropped req. When undefined
//   there is no stall timer and an owner may hold the grant indefinitely.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   req        in   2   per-requester frame request (bit i = requester i)
//   valid      in   2   per-requester sample strobe
//   data0      in   8   sample from requester 0
//   data1      in   8   sample from requester 1
//   gnt        out  2   registered one-hot grant, 2'b00 with no owner
//   cnt        out  6   samples accepted in the current frame (reads 33 at end)
//   sum        out 14   frame sum, meaningful while sum_valid=1
//   sum_valid  out  1   one-cycle pulse: frame completed
//   frame_src  out  1   owner of the frame reported by sum_valid or abort
//   abort      out  1   one-cycle pulse: frame discarded
// -----------------------------------------------------------------------------
module sample_sched (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
    input  logic [1:0]  valid,
    input  logic [7:0]  data0,
    input  logic [7:0]  data1,
    output logic [1:0]  gnt,
    output logic [5:0]  cnt,
    output logic [13:0] sum,
    output logic        sum_valid,
    output logic        frame_src,
    output logic        abort
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam logic [5:0] LAST_IDX = 6'd32;   // cnt value when the 33rd sample lands

    state_e      state_q;
    // last_owner_q is written at grant time, so during BURST it is also the
    // current owner; no separate owner register is needed.
    logic        last_owner_q;
    logic [1:0]  gnt_q;
    logic [5:0]  cnt_q;
    logic [13:0] sum_q;
    logic        sum_valid_q;
    logic        abort_q;
    logic        frame_src_q;

    logic        winner_d;
    logic [7:0]  owner_data_d;
    logic        accept_d;
    logic        stall_abort_d;
    logic        drop_d;
    logic [5:0]  cnt_d;
    logic [13:0] sum_d;

    // On a tie the requester that did not own the previous frame wins;
    // a lone requester wins outright.
    assign winner_d     = (req == 2'b11) ? ~last_owner_q : req[1];
    assign owner_data_d = last_owner_q ? data1 : data0;
    // Only meaningful in BURST; the non-owner's strobe is never looked at.
    assign accept_d     = valid[last_owner_q];
    assign cnt_d        = cnt_q + 6'd1;
    assign sum_d        = sum_q + {6'd0, owner_data_d};

`ifdef SCHED_TIMEOUT_EN
    logic [5:0] idle_q;

    // Counts consecutive BURST cycles with no sample; reaching 63 and missing
    // once more is the 64th empty cycle, which forces an abort.
    assign stall_abort_d = !accept_d && (idle_q == 6'd63);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= 6'd0;
        end else if (state_q == IDLE) begin
            if (req != 2'b00) idle_q <= 6'd0;
        end else if (state_q == BURST) begin
            if (accept_d) idle_q <= 6'd0;
            else          idle_q <= idle_q + 6'd1;
        end
    end
`else
    assign stall_abort_d = 1'b0;
`endif

    assign drop_d = !req[last_owner_q] || stall_abort_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;   // makes requester 0 win the first tie
            gnt_q        <= 2'b00;
            cnt_q        <= 6'd0;
            sum_q        <= 14'd0;
            sum_valid_q  <= 1'b0;
            abort_q      <= 1'b0;
            frame_src_q  <= 1'b0;
        end else begin
            sum_valid_q <= 1'b0;
            abort_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req != 2'b00) begin
                        state_q      <= BURST;
                        last_owner_q <= winner_d;
                        gnt_q        <= winner_d ? 2'b10 : 2'b01;
                        cnt_q        <= 6'd0;
                        sum_q        <= 14'd0;
                    end
                end
                BURST: begin
                    // Abort wins over a same-edge sample, including the 33rd.
                    if (drop_d) begin
                        state_q     <= IDLE;
                        gnt_q       <= 2'b00;
                        abort_q     <= 1'b1;
                        frame_src_q <= last_owner_q;
                    end else if (accept_d) begin
                        cnt_q <= cnt_d;
                        sum_q <= sum_d;
                        if (cnt_q == LAST_IDX) begin
                            state_q     <= DONE;
                            gnt_q       <= 2'b00;
                            sum_valid_q <= 1'b1;
                            frame_src_q <= last_owner_q;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 2'b00;
                end
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign cnt       = cnt_q;
    assign sum       = sum_q;
    assign sum_valid = sum_valid_q;
    assign abort     = abort_q;
    assign frame_src = frame_src_q;

endmodule

// File: tb/tb_sample_sched.sv
module tb_sample_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req, valid;
    logic [7:0]  data0, data1;
    logic [1:0]  gnt;
    logic [5:0]  cnt;
    logic [13:0] sum;
    logic        sum_valid, frame_src, abort;

    always #5 clk = ~clk;

    sample_sched dut (
        .clk(clk), .rst_n(rst_n), .req(req), .valid(valid),
        .data0(data0), .data1(data1), .gnt(gnt), .cnt(cnt), .sum(sum),
        .sum_valid(sum_valid), .frame_src(frame_src), .abort(abort)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: is a frame open, who owns it, what has it collected.
    bit   f_open, f_closing;
    int   f_owner, f_prev_owner, f_samples, f_total, f_empty_run;
    int   e_gnt, e_sv, e_ab, e_src;

    function void m_reset();
        f_open = 0; f_closing = 0; f_owner = 0; f_prev_owner = 1;
        f_samples = 0; f_total = 0; f_empty_run = 0;
        e_gnt = 0; e_sv = 0; e_ab = 0; e_src = 0;
    endfunction

    function void m_step(logic [1:0] r, logic [1:0] v, int d0, int d1);
        bit got, timed_out;
        e_sv = 0; e_ab = 0;
        if (f_closing) begin
            f_closing = 0;                       // one report cycle, then idle
        end else if (!f_open) begin
            if (r != 2'b00) begin
                if (r == 2'b11) f_owner = 1 - f_prev_owner;
                else            f_owner = (r == 2'b10) ? 1 : 0;
                f_prev_owner = f_owner;
                f_open = 1; f_samples = 0; f_total = 0; f_empty_run = 0;
                e_gnt = (f_owner == 1) ? 2 : 1;
            end
        end else begin
            got = v[f_owner];
            timed_out = 0;
`ifdef SCHED_TIMEOUT_EN
            timed_out = !got && (f_empty_run + 1 >= 64);
`endif
            if (!r[f_owner] || timed_out) begin
                f_open = 0; e_gnt = 0; e_ab = 1; e_src = f_owner;
            end else if (got) begin
                f_samples += 1;
                f_total += (f_owner == 1) ? d1 : d0;
                f_empty_run = 0;
                if (f_samples == 33) begin
                    f_open = 0; f_closing = 1; e_gnt = 0; e_sv = 1; e_src = f_owner;
                end
            end else begin
                f_empty_run += 1;
            end
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".gnt"},       gnt,       e_gnt);
        chk({tag, ".cnt"},       cnt,       f_samples);
        chk({tag, ".sum"},       sum,       f_total);
        chk({tag, ".sum_valid"}, sum_valid, e_sv);
        chk({tag, ".abort"},     abort,     e_ab);
        chk({tag, ".frame_src"}, frame_src, e_src);
    endtask

    task automatic tick();
        @(posedge clk);
        m_step(req, valid, data0, data1);
        @(negedge clk);
    endtask

    task automatic step_chk(input string tag);
        tick();
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 2'b00; valid = 2'b00; data0 = 8'd0; data1 = 8'd0;
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] want);
        bit ok = 0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step_chk(tag);
            if (gnt == want) ok = 1;
        end
        chk({tag, ".grant_seen"}, ok, 1);
    endtask

    typedef struct {
        logic [1:0]  req, valid;
        logic [7:0]  d0, d1;
        logic [1:0]  gnt;
        logic [5:0]  cnt;
        logic [13:0] sum;
        logic        sv, ab, src;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int g, sv_at, nfr, gap, ab_at;
        bit in_gap, seen;
        int fr_src[3], fr_sum[3];
        logic [1:0] r;

        tbl[0] = '{2'b00, 2'b00, 8'd0, 8'd0,   2'b00, 6'd0, 14'd0,   1'b0, 1'b0, 1'b0};
        tbl[1] = '{2'b11, 2'b11, 8'd5, 8'd7,   2'b01, 6'd0, 14'd0,   1'b0, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 2'b11, 8'd5, 8'd7,   2'b01, 6'd1, 14'd5,   1'b0, 1'b0, 1'b0};
        tbl[3] = '{2'b01, 2'b10, 8'd3, 8'd9,   2'b01, 6'd1, 14'd5,   1'b0, 1'b0, 1'b0};
        tbl[4] = '{2'b01, 2'b01, 8'd3, 8'd9,   2'b01, 6'd2, 14'd8,   1'b0, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 2'b01, 8'd4, 8'd9,   2'b00, 6'd2, 14'd8,   1'b0, 1'b1, 1'b0};
        tbl[6] = '{2'b10, 2'b00, 8'd4, 8'd9,   2'b10, 6'd0, 14'd0,   1'b0, 1'b0, 1'b0};
        tbl[7] = '{2'b10, 2'b10, 8'd4, 8'd200, 2'b10, 6'd1, 14'd200, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{2'b00, 2'b10, 8'd4, 8'd1,   2'b00, 6'd1, 14'd200, 1'b0, 1'b1, 1'b1};
        tbl[9] = '{2'b11, 2'b00, 8'd4, 8'd1,   2'b01, 6'd0, 14'd0,   1'b0, 1'b0, 1'b1};

        // ---- reset state ----
        rst_n = 1'b0; req = 2'b00; valid = 2'b00; data0 = 8'd0; data1 = 8'd0;
        m_reset();
        @(negedge clk);
        chk("rst.gnt", gnt, 0);       chk("rst.cnt", cnt, 0);
        chk("rst.sum", sum, 0);       chk("rst.sum_valid", sum_valid, 0);
        chk("rst.abort", abort, 0);   chk("rst.frame_src", frame_src, 0);
        rst_n = 1'b1;

        // ---- table vectors ----
        for (int i = 0; i < 10; i++) begin
            req = tbl[i].req; valid = tbl[i].valid; data0 = tbl[i].d0; data1 = tbl[i].d1;
            tick();
            chk($sformatf("tbl%0d.gnt", i), gnt, tbl[i].gnt);
            chk($sformatf("tbl%0d.cnt", i), cnt, tbl[i].cnt);
            chk($sformatf("tbl%0d.sum", i), sum, tbl[i].sum);
            chk($sformatf("tbl%0d.sum_valid", i), sum_valid, tbl[i].sv);
            chk($sformatf("tbl%0d.abort", i), abort, tbl[i].ab);
            chk($sformatf("tbl%0d.frame_src", i), frame_src, tbl[i].src);
        end

        // ---- single requester full frame ----
        do_reset();
        req = 2'b01; valid = 2'b01; data0 = 8'd1;
        g = -1; sv_at = -1;
        for (int i = 0; i < 80 && sv_at < 0; i++) begin
            step_chk("full");
            if (g < 0 && gnt == 2'b01) g = i;
            if (sum_valid) begin
                sv_at = i;
                chk("full.sum", sum, 33);
                chk("full.cnt", cnt, 33);
                chk("full.src", frame_src, 0);
            end
        end
        chk("full.done_seen", sv_at >= 0, 1);
        chk("full.latency", sv_at - g, 33);
        req = 2'b00;
        step_chk("full.post");
        chk("full.post_cnt_hold", cnt, 33);

        // ---- alternating frames under a held tie ----
        do_reset();
        req = 2'b11; valid = 2'b11; data0 = 8'd255; data1 = 8'd2;
        nfr = 0; gap = -1; in_gap = 0;
        for (int i = 0; i < 300 && nfr < 3; i++) begin
            step_chk("alt");
            if (in_gap) begin
                if (gnt == 2'b00) gap++;
                else begin in_gap = 0; chk("alt.gap", gap, 2); end
            end
            if (sum_valid) begin
                fr_src[nfr] = frame_src; fr_sum[nfr] = sum;
                if (nfr == 0) begin in_gap = 1; gap = (gnt == 2'b00) ? 1 : 0; end
                nfr++;
            end
        end
        chk("alt.frames", nfr, 3);
        if (nfr == 3) begin
            chk("alt.src0", fr_src[0], 0); chk("alt.sum0", fr_sum[0], 8415);
            chk("alt.src1", fr_src[1], 1); chk("alt.sum1", fr_sum[1], 66);
            chk("alt.src2", fr_src[2], 0); chk("alt.sum2", fr_sum[2], 8415);
        end

        // ---- owner 1 drops req after 10 samples ----
        do_reset();
        req = 2'b10; valid = 2'b10; data1 = 8'd3;
        wait_gnt("drop", 2'b10);
        for (int i = 0; i < 10; i++) step_chk("drop.acc");
        chk("drop.cnt10", cnt, 10);
        req = 2'b01;
        step_chk("drop.edge");
        chk("drop.abort", abort, 1);
        chk("drop.src", frame_src, 1);
        chk("drop.no_sv", sum_valid, 0);
        chk("drop.gnt0", gnt, 0);
        req = 2'b11;
        step_chk("drop.regrant");
        chk("drop.next_gnt", gnt, 2'b01);
        chk("drop.abort_once", abort, 0);

        // ---- owner valid toggles, non-owner always valid ----
        do_reset();
        req = 2'b01; data0 = 8'd1; data1 = 8'd100; valid = 2'b10;
        g = -1; sv_at = -1;
        for (int i = 0; i < 120 && sv_at < 0; i++) begin
            valid = {1'b1, (g >= 0) && ((i - g) % 2 == 1)};
            step_chk("tog");
            if (g < 0 && gnt == 2'b01) g = i;
            if (sum_valid) begin
                sv_at = i;
                chk("tog.sum", sum, 33);
                chk("tog.src", frame_src, 0);
            end
        end
        chk("tog.done_seen", sv_at >= 0, 1);
        chk("tog.latency", sv_at - g, 65);

        // ---- reset mid-frame ----
        do_reset();
        req = 2'b01; valid = 2'b01; data0 = 8'd2;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step_chk("mrst");
            if (cnt == 6'd20) seen = 1;
        end
        chk("mrst.reached20", seen, 1);
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mrst.gnt", gnt, 0);     chk("mrst.cnt", cnt, 0);
        chk("mrst.sum", sum, 0);     chk("mrst.sv", sum_valid, 0);
        chk("mrst.abort", abort, 0); chk("mrst.src", frame_src, 0);
        @(negedge clk);
        check_all("mrst.hold");
        rst_n = 1'b1; req = 2'b11; valid = 2'b00;
        step_chk("mrst.first");
        chk("mrst.first_gnt", gnt, 2'b01);

        // ---- owner stalls after 5 samples ----
        do_reset();
        req = 2'b01; valid = 2'b01; data0 = 8'd7;
        wait_gnt("stall", 2'b01);
        for (int i = 0; i < 5; i++) step_chk("stall.acc");
        chk("stall.cnt5", cnt, 5);
        valid = 2'b00;
        ab_at = -1;
        for (int t = 1; t <= 70; t++) begin
            step_chk("stall");
            if (abort && ab_at < 0) ab_at = t;
        end
`ifdef SCHED_TIMEOUT_EN
        chk("stall.abort_at", ab_at, 64);
`else
        chk("stall.no_abort", ab_at, -1);
        chk("stall.still_owned", gnt, 2'b01);
`endif

        // ---- randomized traffic against the model ----
        do_reset();
        r = 2'b00;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) == 0) r[0] = ~r[0];
            if ($urandom_range(0, 99) == 0) r[1] = ~r[1];
            req = r;
            valid = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) valid = 2'b11;
            data0 = 8'($urandom); data1 = 8'($urandom);
            step_chk("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
